// File: rtl/processor_stage2_if.sv
// Fetch-to-decode bus for processor_stage2: fetched instruction, flush,
// register-file write-back port, stall feedback and the registered decode outputs.
interface processor_stage2_if #(
   parameter int ADDR_SIZE = 18,
   parameter int WORD_SIZE = 18
);
   logic                 no_operation_in;
   logic [ADDR_SIZE-1:0] ip_in;
   logic [ADDR_SIZE-1:0] ip_plus_one_in;
   logic [WORD_SIZE-1:0] code_word;
   logic                 flush;
   logic                 wb_enable;
   logic [2:0]           wb_index;
   logic [WORD_SIZE-1:0] wb_data;
   logic                 stall;
   logic                 no_operation_out;
   logic [ADDR_SIZE-1:0] ip_out;
   logic [ADDR_SIZE-1:0] ip_plus_one_out;
   logic [2:0]           alu_op;
   logic                 use_imm;
   logic                 is_load;
   logic                 is_store;
   logic                 is_branch;
   logic                 writes_rd;
   logic [2:0]           rd_index;
   logic [WORD_SIZE-1:0] operand_a;
   logic [WORD_SIZE-1:0] operand_b;
   logic [WORD_SIZE-1:0] store_data;

   modport master (
      output no_operation_in, ip_in, ip_plus_one_in, code_word, flush,
             wb_enable, wb_index, wb_data,
      input  stall, no_operation_out, ip_out, ip_plus_one_out, alu_op,
             use_imm, is_load, is_store, is_branch, writes_rd, rd_index,
             operand_a, operand_b, store_data
   );

   modport slave (
      input  no_operation_in, ip_in, ip_plus_one_in, code_word, flush,
             wb_enable, wb_index, wb_data,
      output stall, no_operation_out, ip_out, ip_plus_one_out, alu_op,
             use_imm, is_load, is_store, is_branch, writes_rd, rd_index,
             operand_a, operand_b, store_data
   );
endinterface

// File: rtl/processor_stage2.sv
// Decode stage: instruction decode, 8-entry register file with write-back bypass,
// and load-use interlock that parks the dependent instruction for one cycle.
//
// state   | meaning
// ST_RUN  | decode from code_word/ip_in
// ST_HELD | decode the instruction parked by the last load-use stall
module processor_stage2 #(
   parameter int ADDR_SIZE = 18,
   parameter int WORD_SIZE = 18
) (
   input logic clock,
   input logic reset,
   processor_stage2_if.slave bus
);
   typedef enum logic {ST_RUN, ST_HELD} state_t;

   state_t               state, state_nxt;
   logic [WORD_SIZE-1:0] regs [8];
   logic [WORD_SIZE-1:0] hold_word;
   logic [ADDR_SIZE-1:0] hold_ip, hold_ipp;

   logic [WORD_SIZE-1:0] cur_word;
   logic [ADDR_SIZE-1:0] cur_ip, cur_ipp;
   logic                 cur_valid;
   logic [3:0]           opcode;
   logic [2:0]           rd, rs1, rs2;
   logic [WORD_SIZE-1:0] simm5, simm11, rs1_val, rs2_val;
   logic                 use_rs1, use_rs2, load_use, stall, emit;

   logic [2:0]           d_alu_op;
   logic                 d_use_imm, d_is_load, d_is_store, d_is_branch, d_writes_rd;
   logic [WORD_SIZE-1:0] d_operand_a, d_operand_b, d_store_data;

   assign cur_word  = (state == ST_HELD) ? hold_word : bus.code_word;
   assign cur_ip    = (state == ST_HELD) ? hold_ip   : bus.ip_in;
   assign cur_ipp   = (state == ST_HELD) ? hold_ipp  : bus.ip_plus_one_in;
   assign cur_valid = (state == ST_HELD) || !bus.no_operation_in;

   assign opcode = cur_word[17:14];
   assign rd     = cur_word[13:11];
   assign rs1    = cur_word[10:8];
   assign rs2    = cur_word[7:5];
   assign simm5  = {{(WORD_SIZE-5){cur_word[4]}}, cur_word[4:0]};
   assign simm11 = {{(WORD_SIZE-11){cur_word[10]}}, cur_word[10:0]};

   // Write-back to the same index this cycle is forwarded; r0 is hardwired zero.
   always_comb begin
      rs1_val = regs[rs1];
      if (rs1 == 3'd0)
         rs1_val = '0;
      else if (bus.wb_enable && bus.wb_index == rs1)
         rs1_val = bus.wb_data;
   end

   always_comb begin
      rs2_val = regs[rs2];
      if (rs2 == 3'd0)
         rs2_val = '0;
      else if (bus.wb_enable && bus.wb_index == rs2)
         rs2_val = bus.wb_data;
   end

   assign use_rs1 = (opcode != 4'hF);
   assign use_rs2 = !opcode[3] || (opcode == 4'hD) || (opcode == 4'hE);

   // A parked instruction always follows a bubble, so it can never re-stall.
   assign load_use = cur_valid && (state == ST_RUN) && bus.is_load && !bus.no_operation_out
                     && (bus.rd_index != 3'd0)
                     && ((use_rs1 && rs1 == bus.rd_index) || (use_rs2 && rs2 == bus.rd_index));
   assign stall    = load_use && !bus.flush && !reset;
   assign emit     = cur_valid && !stall && !bus.flush;
   assign bus.stall = stall;

   always_ff @(posedge clock) begin
      if (reset) state <= ST_RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:  if (stall) state_nxt = ST_HELD;
         ST_HELD: state_nxt = ST_RUN;
         default: state_nxt = ST_RUN;
      endcase
      if (bus.flush) state_nxt = ST_RUN;
   end

   always_comb begin
      d_alu_op     = 3'd0;
      d_use_imm    = 1'b0;
      d_is_load    = 1'b0;
      d_is_store   = 1'b0;
      d_is_branch  = 1'b0;
      d_writes_rd  = 1'b0;
      d_operand_a  = rs1_val;
      d_operand_b  = simm5;
      d_store_data = '0;
      if (!opcode[3]) begin
         d_alu_op    = opcode[2:0];
         d_operand_b = rs2_val;
         d_writes_rd = (rd != 3'd0);
      end else begin
         case (opcode[2:0])
            3'd4: begin
               d_is_load   = 1'b1;
               d_writes_rd = (rd != 3'd0);
            end
            3'd5: begin
               d_is_store   = 1'b1;
               d_store_data = rs2_val;
            end
            3'd6: begin
               d_is_branch  = 1'b1;
               d_store_data = rs2_val;
            end
            3'd7: begin
               d_operand_a = '0;
               d_operand_b = simm11;
               d_writes_rd = (rd != 3'd0);
            end
            default: begin
               d_alu_op    = {1'b0, opcode[1:0]};
               d_use_imm   = 1'b1;
               d_writes_rd = (rd != 3'd0);
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset || !emit) begin
         bus.no_operation_out <= 1'b1;
         bus.ip_out           <= '0;
         bus.ip_plus_one_out  <= '0;
         bus.alu_op           <= 3'd0;
         bus.use_imm          <= 1'b0;
         bus.is_load          <= 1'b0;
         bus.is_store         <= 1'b0;
         bus.is_branch        <= 1'b0;
         bus.writes_rd        <= 1'b0;
         bus.rd_index         <= 3'd0;
         bus.operand_a        <= '0;
         bus.operand_b        <= '0;
         bus.store_data       <= '0;
      end else begin
         bus.no_operation_out <= 1'b0;
         bus.ip_out           <= cur_ip;
         bus.ip_plus_one_out  <= cur_ipp;
         bus.alu_op           <= d_alu_op;
         bus.use_imm          <= d_use_imm;
         bus.is_load          <= d_is_load;
         bus.is_store         <= d_is_store;
         bus.is_branch        <= d_is_branch;
         bus.writes_rd        <= d_writes_rd;
         bus.rd_index         <= rd;
         bus.operand_a        <= d_operand_a;
         bus.operand_b        <= d_operand_b;
         bus.store_data       <= d_store_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hold_word <= '0;
         hold_ip   <= '0;
         hold_ipp  <= '0;
      end else if (stall) begin
         hold_word <= bus.code_word;
         hold_ip   <= bus.ip_in;
         hold_ipp  <= bus.ip_plus_one_in;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else if (bus.wb_enable && bus.wb_index != 3'd0) begin
         regs[bus.wb_index] <= bus.wb_data;
      end
   end
endmodule

// File: tb/tb_processor_stage2.sv
// Directed bench for processor_stage2: decode, bypass, LDI, load-use stall,
// flush and reset behaviour, with hand-computed expectations.
module tb_processor_stage2;
   localparam int AW = 18;
   localparam int WW = 18;

   logic clock = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   processor_stage2_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW)) bus ();

   processor_stage2 #(.ADDR_SIZE(AW), .WORD_SIZE(WW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [17:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [4:0] imm);
      return {op, rd, rs1, rs2, imm};
   endfunction

   function automatic logic [17:0] ldi(input logic [2:0] rd, input logic [10:0] imm);
      return {4'hF, rd, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic nop, input logic [17:0] word, input logic [17:0] ip);
      bus.no_operation_in = nop;
      bus.code_word       = word;
      bus.ip_in           = ip;
      bus.ip_plus_one_in  = ip + 18'd1;
      #1;
   endtask

   function automatic logic [4:0] flags();
      return {bus.use_imm, bus.is_load, bus.is_store, bus.is_branch, bus.writes_rd};
   endfunction

   initial begin
      reset = 1'b1;
      bus.flush = 1'b0;
      bus.wb_enable = 1'b0;
      bus.wb_index = 3'd0;
      bus.wb_data = '0;
      drive(1'b0, enc(4'h0, 3'd1, 3'd1, 3'd1, 5'd0), 18'h5);
      step();
      step();
      chk("rst_nop", bus.no_operation_out, 1);
      chk("rst_flags", flags(), 0);
      chk("rst_opa", bus.operand_a, 0);
      chk("rst_stall", bus.stall, 0);

      reset = 1'b0;
      bus.wb_enable = 1'b1; bus.wb_index = 3'd3; bus.wb_data = 18'h00005;
      drive(1'b1, 18'h0, 18'h0);
      step();
      chk("nop_in_bubble", bus.no_operation_out, 1);

      bus.wb_enable = 1'b0;
      drive(1'b0, enc(4'h0, 3'd1, 3'd3, 3'd3, 5'd0), 18'h10);
      step();
      chk("rr_nop", bus.no_operation_out, 0);
      chk("rr_opa", bus.operand_a, 5);
      chk("rr_opb", bus.operand_b, 5);
      chk("rr_flags", flags(), 5'b00001);
      chk("rr_rd", bus.rd_index, 1);
      chk("rr_ip", bus.ip_out, 18'h10);
      chk("rr_ipp", bus.ip_plus_one_out, 18'h11);

      bus.wb_enable = 1'b1; bus.wb_index = 3'd2; bus.wb_data = 18'h3FFFF;
      drive(1'b0, enc(4'h9, 3'd2, 3'd2, 3'd0, 5'h10), 18'h11);
      step();
      chk("byp_opa", bus.operand_a, 18'h3FFFF);
      chk("imm_opb", bus.operand_b, 18'h3FFF0);
      chk("imm_alu", bus.alu_op, 1);
      chk("imm_flags", flags(), 5'b10001);

      bus.wb_enable = 1'b0;
      drive(1'b0, enc(4'h5, 3'd6, 3'd2, 3'd3, 5'd0), 18'h12);
      step();
      chk("rf_opa", bus.operand_a, 18'h3FFFF);
      chk("rf_opb", bus.operand_b, 5);
      chk("rf_alu", bus.alu_op, 5);

      bus.wb_enable = 1'b1; bus.wb_index = 3'd0; bus.wb_data = 18'h7;
      drive(1'b0, enc(4'h0, 3'd1, 3'd0, 3'd0, 5'd0), 18'h13);
      step();
      chk("r0_byp", bus.operand_a, 0);
      bus.wb_enable = 1'b0;
      drive(1'b0, enc(4'h0, 3'd1, 3'd0, 3'd3, 5'd0), 18'h14);
      step();
      chk("r0_read", bus.operand_a, 0);
      chk("r0_opb", bus.operand_b, 5);

      drive(1'b0, ldi(3'd4, 11'h7FF), 18'h15);
      step();
      chk("ldi_opb", bus.operand_b, 18'h3FFFF);
      chk("ldi_opa", bus.operand_a, 0);
      chk("ldi_flags", flags(), 5'b00001);
      chk("ldi_rd", bus.rd_index, 4);
      drive(1'b0, ldi(3'd0, 11'h005), 18'h16);
      step();
      chk("ldi0_flags", flags(), 5'b00000);
      chk("ldi0_opb", bus.operand_b, 5);

      drive(1'b0, enc(4'hD, 3'd0, 3'd3, 3'd2, 5'd1), 18'h17);
      step();
      chk("st_flags", flags(), 5'b00100);
      chk("st_opa", bus.operand_a, 5);
      chk("st_opb", bus.operand_b, 1);
      chk("st_data", bus.store_data, 18'h3FFFF);

      // load-use: stall one cycle, bubble, then the parked ALU with its own ip
      drive(1'b0, enc(4'hC, 3'd5, 3'd3, 3'd0, 5'd2), 18'h20);
      step();
      chk("ld_flags", flags(), 5'b01001);
      chk("ld_opb", bus.operand_b, 2);
      drive(1'b0, enc(4'h0, 3'd7, 3'd5, 3'd3, 5'd0), 18'h21);
      chk("lu_stall", bus.stall, 1);
      step();
      chk("lu_bubble", bus.no_operation_out, 1);
      chk("lu_bflags", flags(), 0);
      drive(1'b1, 18'h0, 18'h0);
      chk("held_nostall", bus.stall, 0);
      step();
      chk("held_nop", bus.no_operation_out, 0);
      chk("held_ip", bus.ip_out, 18'h21);
      chk("held_ipp", bus.ip_plus_one_out, 18'h22);
      chk("held_rd", bus.rd_index, 7);
      chk("held_opb", bus.operand_b, 5);
      chk("held_flags", flags(), 5'b00001);

      // bubble input after a load: no stall, hold untouched
      drive(1'b0, enc(4'hC, 3'd5, 3'd3, 3'd0, 5'd2), 18'h30);
      step();
      drive(1'b1, enc(4'h0, 3'd7, 3'd5, 3'd3, 5'd0), 18'h31);
      chk("nopin_stall", bus.stall, 0);
      step();
      chk("nopin_out", bus.no_operation_out, 1);

      drive(1'b0, enc(4'hC, 3'd5, 3'd3, 3'd0, 5'd2), 18'h32);
      step();
      drive(1'b0, ldi(3'd5, 11'h003), 18'h33);
      chk("ldi_nostall", bus.stall, 0);
      step();
      chk("ldi_after_ld", bus.operand_b, 3);

      // flush during a load-use hazard
      drive(1'b0, enc(4'hC, 3'd5, 3'd3, 3'd0, 5'd2), 18'h38);
      step();
      bus.flush = 1'b1;
      drive(1'b0, enc(4'h0, 3'd7, 3'd5, 3'd3, 5'd0), 18'h39);
      chk("fl_stall", bus.stall, 0);
      step();
      chk("fl_bubble", bus.no_operation_out, 1);
      bus.flush = 1'b0;
      drive(1'b0, enc(4'h2, 3'd1, 3'd3, 3'd3, 5'd0), 18'h40);
      chk("fl_after_stall", bus.stall, 0);
      step();
      chk("fl_next_nop", bus.no_operation_out, 0);
      chk("fl_next_ip", bus.ip_out, 18'h40);
      chk("fl_next_alu", bus.alu_op, 2);

      // reset mid-stall
      drive(1'b0, enc(4'hC, 3'd5, 3'd3, 3'd0, 5'd2), 18'h50);
      step();
      drive(1'b0, enc(4'h0, 3'd7, 3'd5, 3'd3, 5'd0), 18'h51);
      chk("rs_stall_pre", bus.stall, 1);
      reset = 1'b1;
      step();
      chk("rs_nop", bus.no_operation_out, 1);
      chk("rs_flags", flags(), 0);
      reset = 1'b0;
      drive(1'b1, 18'h0, 18'h0);
      chk("rs_stall_post", bus.stall, 0);
      step();
      chk("rs_held_gone", bus.no_operation_out, 1);
      drive(1'b0, enc(4'h0, 3'd1, 3'd3, 3'd3, 5'd0), 18'h60);
      step();
      chk("rs_rf_clear", bus.operand_a, 0);
      chk("rs_ip", bus.ip_out, 18'h60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
